// File: rtl/multdiv_ctrl_pkg.sv
// Shared ISA constants and state encoding for the multiply/divide issue
// controller. Decode values are the instr[31:27] / instr[6:2] fields of
// an R-type mult/div; RSTATUS_REG and the EXC_* codes describe the status
// writeback used when the multdiv unit faults or never answers.
package multdiv_ctrl_pkg;

  localparam logic [4:0]  OPC_RTYPE   = 5'b00000;
  localparam logic [4:0]  ALU_MULT    = 5'b00110;
  localparam logic [4:0]  ALU_DIV     = 5'b00111;

  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] EXC_MULT    = 32'd4;
  localparam logic [31:0] EXC_DIV     = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  // Status code written to RSTATUS_REG for a faulted/aborted operation.
  function automatic logic [31:0] exc_code(input logic is_div);
    return is_div ? EXC_DIV : EXC_MULT;
  endfunction

endpackage

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: issues one mult/div at a time to an external multdiv unit,
// stalls the front end while it runs, and produces the register-file
// writeback (normal result, exception status, or timeout abort).
//
// Ports
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   in_valid, opcode,
//   alu_op, rd              : decoded instruction (sampled only in IDLE)
//   operand_a, operand_b    : rs / rt read data
//   md_ctrl_mult/div        : one-cycle start pulses (START state)
//   md_a, md_b              : operands latched at acceptance, held while busy
//   md_ready, md_exception,
//   md_result               : unit completion, sampled only in WAIT
//   stall                   : front-end freeze (combinational)
//   wb_valid, wb_reg,
//   wb_data                 : register-file write request (WB state)
//   timeout                 : accompanies wb_valid on an abort writeback
//   state_dbg               : current FSM state (state_t encoding)
//
// Handshake: a mult/div is accepted in the IDLE cycle where in_valid is high
// and the decode matches; there is no ready back-pressure on the decode side
// beyond stall. md_ready is a single-cycle completion strobe that is only
// meaningful in WAIT; in any other state it is ignored.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [4:0]  opcode,
  input  logic [4:0]  alu_op,
  input  logic [4:0]  rd,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        timeout,
  output logic [1:0]  state_dbg
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int          CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic          is_mult, is_div, is_md;
  logic          op_div_q;
  logic [4:0]    rd_q;
  logic [CW-1:0] cnt;
  logic          wb_en_q;
  logic          abort_q;

  // Inline decode.
  always_comb begin
    is_mult = (opcode == OPC_RTYPE) && (alu_op == ALU_MULT);
    is_div  = (opcode == OPC_RTYPE) && (alu_op == ALU_DIV);
    is_md   = is_mult || is_div;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_valid && is_md) state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (md_ready || (cnt == CNT_LAST)) state_nxt = ST_WB;
      ST_WB:    state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Combinational outputs are forced low while reset is asserted so reset
  // wins over any in-flight state in the same cycle.
  always_comb begin
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    stall        = 1'b0;
    wb_valid     = 1'b0;
    timeout      = 1'b0;
    if (!reset) begin
      md_ctrl_mult = (state == ST_START) && !op_div_q;
      md_ctrl_div  = (state == ST_START) &&  op_div_q;
      stall        = (state != ST_IDLE) || (in_valid && is_md);
      wb_valid     = (state == ST_WB) && wb_en_q;
      timeout      = (state == ST_WB) && abort_q;
    end
  end

  assign state_dbg = state;

  // Datapath: operand/destination latch, wait counter, writeback capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_div_q <= 1'b0;
      rd_q     <= '0;
      md_a     <= '0;
      md_b     <= '0;
      cnt      <= '0;
      wb_en_q  <= 1'b0;
      abort_q  <= 1'b0;
      wb_reg   <= '0;
      wb_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && is_md) begin
            op_div_q <= is_div;
            rd_q     <= rd;
            md_a     <= operand_a;
            md_b     <= operand_b;
          end
        end
        ST_START: cnt <= '0;
        ST_WAIT: begin
          if (md_ready) begin
            abort_q <= 1'b0;
            if (md_exception) begin
              // Status writes are never suppressed, even for rd=0.
              wb_en_q <= 1'b1;
              wb_reg  <= RSTATUS_REG;
              wb_data <= exc_code(op_div_q);
            end else begin
              wb_en_q <= (rd_q != 5'd0);
              wb_reg  <= rd_q;
              wb_data <= md_result;
            end
          end else if (cnt == CNT_LAST) begin
            abort_q <= 1'b1;
            wb_en_q <= 1'b1;
            wb_reg  <= RSTATUS_REG;
            wb_data <= exc_code(op_div_q);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
module tb_multdiv_ctrl;
  import multdiv_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  opcode, alu_op, rd;
  logic [31:0] operand_a, operand_b;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_a, md_b;
  logic        md_ready, md_exception;
  logic [31:0] md_result;
  logic        stall, wb_valid, timeout;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [1:0]  state_dbg;

  always #5 clock = ~clock;

  multdiv_ctrl #(.TIMEOUT(40)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .opcode(opcode),
    .alu_op(alu_op), .rd(rd), .operand_a(operand_a), .operand_b(operand_b),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_a(md_a), .md_b(md_b), .md_ready(md_ready),
    .md_exception(md_exception), .md_result(md_result), .stall(stall),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .timeout(timeout), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  // expected writeback: {timeout, wb_reg, wb_data}
  logic [37:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the current WB-cycle outputs against the head of exp_q.
  task automatic chk_wb(input string tag);
    logic [37:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
      chk({tag, "_timeout"},  {31'd0, timeout},  {31'd0, e[37]});
      chk({tag, "_wb_reg"},   {27'd0, wb_reg},   {27'd0, e[36:32]});
      chk({tag, "_wb_data"},  wb_data,           e[31:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    opcode    = 5'd0;
    alu_op    = 5'd0;
    rd        = 5'd0;
    operand_a = 32'd0;
    operand_b = 32'd0;
  endtask

  // Present a mult/div in IDLE, check stall, accept it and check START.
  task automatic issue(input string tag, input logic is_div, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid  = 1'b1;
    opcode    = 5'b00000;
    alu_op    = is_div ? 5'b00111 : 5'b00110;
    rd        = r;
    operand_a = a;
    operand_b = b;
    #1;
    chk({tag, "_stall_accept"}, {31'd0, stall}, 32'd1);
    tick();
    idle_inputs();
    #1;
    chk({tag, "_start_state"}, {30'd0, state_dbg}, {30'd0, ST_START});
    chk({tag, "_start_mult"},  {31'd0, md_ctrl_mult}, {31'd0, ~is_div});
    chk({tag, "_start_div"},   {31'd0, md_ctrl_div},  {31'd0, is_div});
    chk({tag, "_md_a"}, md_a, a);
    chk({tag, "_md_b"}, md_b, b);
    tick(); // now in first WAIT cycle
  endtask

  // Spend n WAIT cycles with md_ready low, checking stall and no pulses.
  task automatic wait_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_wait_stall"}, {31'd0, stall}, 32'd1);
      chk({tag, "_wait_pulse"}, {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
      tick();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    md_ready = 1'b0; md_exception = 1'b0; md_result = 32'd0;
    idle_inputs();
    tick(); tick();
    chk("rst_state",   {30'd0, state_dbg}, {30'd0, ST_IDLE});
    chk("rst_outs",    {27'd0, stall, wb_valid, timeout, md_ctrl_mult, md_ctrl_div}, 32'd0);
    chk("rst_wb_reg",  {27'd0, wb_reg}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_md_ab",   md_a | md_b, 32'd0);
    reset = 1'b0;
    tick();

    // mult rd=5, 6*7, ready after 10 WAIT cycles
    issue("mul", 1'b0, 5'd5, 32'd6, 32'd7);
    // a decoded div while busy must be ignored
    in_valid = 1'b1; alu_op = 5'b00111; rd = 5'd9; operand_a = 32'hdead;
    wait_cycles("mul", 9);
    idle_inputs();
    chk("mul_md_a_hold", md_a, 32'd6);
    md_ready = 1'b1; md_result = 32'd42;
    exp_q.push_back({1'b0, 5'd5, 32'd42});
    tick();
    md_ready = 1'b0; md_result = 32'd0;
    chk_wb("mul");
    chk("mul_wb_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("mul_idle_wbv",  {31'd0, wb_valid}, 32'd0);
    chk("mul_idle_stall", {31'd0, stall}, 32'd0);

    // div with exception after 3 WAIT cycles
    issue("dexc", 1'b1, 5'd9, 32'd100, 32'd0);
    wait_cycles("dexc", 3);
    md_ready = 1'b1; md_exception = 1'b1; md_result = 32'd123;
    exp_q.push_back({1'b0, 5'd30, 32'd5});
    tick();
    md_ready = 1'b0; md_exception = 1'b0;
    chk_wb("dexc");
    tick();

    // mult with no md_ready: abort after 40 WAIT cycles
    issue("abort", 1'b0, 5'd3, 32'd2, 32'd3);
    wait_cycles("abort", 39);
    chk("abort_last_wait", {30'd0, state_dbg}, {30'd0, ST_WAIT});
    chk("abort_last_to",   {31'd0, timeout}, 32'd0);
    exp_q.push_back({1'b1, 5'd30, 32'd4});
    tick();
    chk_wb("abort");
    tick();
    chk("abort_to_clear", {31'd0, timeout}, 32'd0);
    chk("abort_idle",     {30'd0, state_dbg}, {30'd0, ST_IDLE});

    // mult with rd=0: no writeback
    issue("rd0", 1'b0, 5'd0, 32'd11, 32'd7);
    wait_cycles("rd0", 2);
    md_ready = 1'b1; md_result = 32'd77;
    tick();
    md_ready = 1'b0;
    chk("rd0_wb_state", {30'd0, state_dbg}, {30'd0, ST_WB});
    chk("rd0_no_wbv",   {30'd0, wb_valid, timeout}, 32'd0);
    tick();
    chk("rd0_idle",  {30'd0, state_dbg}, {30'd0, ST_IDLE});
    chk("rd0_stall", {31'd0, stall}, 32'd0);

    // reset in the 3rd WAIT cycle
    issue("rstw", 1'b0, 5'd7, 32'd11, 32'd13);
    wait_cycles("rstw", 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstw_state",   {30'd0, state_dbg}, {30'd0, ST_IDLE});
    chk("rstw_outs",    {27'd0, stall, wb_valid, timeout, md_ctrl_mult, md_ctrl_div}, 32'd0);
    chk("rstw_wb_reg",  {27'd0, wb_reg}, 32'd0);
    chk("rstw_wb_data", wb_data, 32'd0);
    chk("rstw_md_ab",   md_a | md_b, 32'd0);
    md_ready = 1'b1; md_result = 32'd99;
    tick();
    chk("rstw_late_ready", {29'd0, wb_valid, stall, timeout}, 32'd0);
    tick();
    chk("rstw_late_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    md_ready = 1'b0;

    // non-mult/div encodings are ignored
    in_valid = 1'b1; opcode = 5'b00000; alu_op = 5'b00000;
    #1;
    chk("add_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("add_no_pulse", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
    opcode = 5'b00001; alu_op = 5'b00110;
    #1;
    chk("badopc_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("badopc_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    idle_inputs();

    // md_ready held high through START: must only be taken in WAIT
    md_ready = 1'b1; md_result = 32'd55;
    issue("early", 1'b0, 5'd4, 32'd5, 32'd11);
    chk("early_in_wait", {30'd0, state_dbg}, {30'd0, ST_WAIT});
    exp_q.push_back({1'b0, 5'd4, 32'd55});
    tick();
    md_ready = 1'b0;
    chk_wb("early");
    tick();
    // back-to-back: new op in the IDLE return cycle
    in_valid = 1'b1; opcode = 5'b00000; alu_op = 5'b00111; rd = 5'd6;
    #1;
    chk("b2b_stall", {31'd0, stall}, 32'd1);
    tick();
    idle_inputs();
    chk("b2b_div_pulse", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd1);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
